rv32i_control_path: RTL and testbench

- Combined RV32I decode, control and arithmetic block for the multi-cycle CPU core.
- Decodes the instruction register into fields and a sign-extended immediate, and runs the FETCH/EXECUTE/WRITEBACK sequencer.
- Produces datapath control signals (mux selects, bus strobes, ALU mode) and the ALU result consumed by the register file, PC and memory unit.

---
 rtl/rv32i_control_path_pkg.sv | 55 +++++
 rtl/rv32i_control_path_alu.sv | 37 +++
 rtl/rv32i_control_path.sv | 171 +++++++++++++++++
 tb/tb_rv32i_control_path.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rv32i_control_path_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle control path.
package rv32i_control_path_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_mode_t;

    typedef enum logic [1:0] {
        DEST_NONE    = 2'd0,
        DEST_ALU     = 2'd1,
        DEST_MEM     = 2'd2,
        DEST_NEXT_PC = 2'd3
    } dest_reg_from_t;

    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_EXECUTE   = 2'd1,
        ST_WRITEBACK = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Shared f3 mapping of the register/immediate arithmetic group.
    function automatic alu_mode_t arith_mode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_mode = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_mode = ALU_SLL;
            3'b010:  arith_mode = ALU_SLT;
            3'b011:  arith_mode = ALU_SLTU;
            3'b100:  arith_mode = ALU_XOR;
            3'b101:  arith_mode = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_mode = ALU_OR;
            default: arith_mode = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_control_path_alu.sv
// Combinational RV32I ALU; shift amount comes from in_b[4:0].
module rv32i_alu
    import rv32i_control_path_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_mode_t        mode,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    logic [4:0] shamt;
    assign shamt = in_b[4:0];

    always_comb begin
        result = '0;
        case (mode)
            ALU_ADD:    result = in_a + in_b;
            ALU_SUB:    result = in_a - in_b;
            ALU_SLL:    result = in_a << shamt;
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, in_a < in_b};
            ALU_XOR:    result = in_a ^ in_b;
            ALU_SRL:    result = in_a >> shamt;
            ALU_SRA:    result = $unsigned($signed(in_a) >>> shamt);
            ALU_OR:     result = in_a | in_b;
            ALU_AND:    result = in_a & in_b;
            ALU_PASS_B: result = in_b;
            default:    result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rv32i_control_path.sv
// RV32I decode, control generation and FETCH/EXECUTE/WRITEBACK sequencer.
module rv32i_control_path
    import rv32i_control_path_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ir,
    input  logic             stall,
    input  logic [XLEN-1:0]  alu_in_a,
    input  logic [XLEN-1:0]  alu_in_b,
    output logic [XLEN-1:0]  alu_out,
    output logic             alu_zero,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       f3,
    output logic [6:0]       f7,
    output logic [31:0]      imm,
    output logic [31:0]      len,
    output logic [3:0]       alu_mode,
    output logic             invert_logic_result,
    output logic             alu_in_a_sel,
    output logic             alu_in_b_sel,
    output logic [1:0]       dest_reg_from,
    output logic             pc_src_alu,
    output logic             branching,
    output logic             dbus_re,
    output logic             dbus_we,
    output logic             load_ir,
    output logic             en_iaddr,
    output logic             en_pc_counter,
    output logic             write_back_stage
);

    state_t         state_reg;
    state_t         state_next;
    alu_mode_t      mode_dec;
    dest_reg_from_t dest_dec;
    logic           pc_src_dec;
    logic           branch_dec;
    logic           re_dec;
    logic           we_dec;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign len    = 32'd4;

    always_comb begin
        imm = 32'd0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {ir[31:12], 12'd0};
            OPC_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:    imm = 32'd0;
        endcase
    end

    always_comb begin
        mode_dec            = ALU_ADD;
        dest_dec            = DEST_NONE;
        invert_logic_result = 1'b0;
        alu_in_a_sel        = 1'b0;
        alu_in_b_sel        = 1'b0;
        pc_src_dec          = 1'b0;
        branch_dec          = 1'b0;
        re_dec              = 1'b0;
        we_dec              = 1'b0;
        case (opcode)
            OPC_OP: begin
                mode_dec = arith_mode(f3, f7[5]);
                dest_dec = DEST_ALU;
            end
            OPC_OP_IMM: begin
                // Only SRAI uses the alternate bit; ADDI's imm[10] must not select SUB.
                mode_dec     = arith_mode(f3, f7[5] && (f3 == 3'b101));
                alu_in_b_sel = 1'b1;
                dest_dec     = DEST_ALU;
            end
            OPC_LUI: begin
                mode_dec     = ALU_PASS_B;
                alu_in_b_sel = 1'b1;
                dest_dec     = DEST_ALU;
            end
            OPC_AUIPC: begin
                alu_in_a_sel = 1'b1;
                alu_in_b_sel = 1'b1;
                dest_dec     = DEST_ALU;
            end
            OPC_JAL: begin
                alu_in_a_sel = 1'b1;
                alu_in_b_sel = 1'b1;
                pc_src_dec   = 1'b1;
                dest_dec     = DEST_NEXT_PC;
            end
            OPC_JALR: begin
                alu_in_b_sel = 1'b1;
                pc_src_dec   = 1'b1;
                dest_dec     = DEST_NEXT_PC;
            end
            OPC_BRANCH: begin
                branch_dec = 1'b1;
                case (f3)
                    3'b000:  begin mode_dec = ALU_SUB;  invert_logic_result = 1'b1; end
                    3'b001:  mode_dec = ALU_SUB;
                    3'b100:  mode_dec = ALU_SLT;
                    3'b101:  begin mode_dec = ALU_SLT;  invert_logic_result = 1'b1; end
                    3'b110:  mode_dec = ALU_SLTU;
                    3'b111:  begin mode_dec = ALU_SLTU; invert_logic_result = 1'b1; end
                    default: branch_dec = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                alu_in_b_sel = 1'b1;
                re_dec       = 1'b1;
                dest_dec     = DEST_MEM;
            end
            OPC_STORE: begin
                alu_in_b_sel = 1'b1;
                we_dec       = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_mode = mode_dec;

    always_comb begin
        state_next = state_reg;
        if (!stall) begin
            case (state_reg)
                ST_FETCH:   state_next = ST_EXECUTE;
                ST_EXECUTE: state_next = ST_WRITEBACK;
                default:    state_next = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_FETCH;
        else     state_reg <= state_next;
    end

    // Stage qualifiers derive straight from the state register, so reset takes effect at once.
    assign load_ir          = (state_reg == ST_FETCH);
    assign en_iaddr         = (state_reg == ST_FETCH);
    assign write_back_stage = (state_reg == ST_WRITEBACK);
    assign en_pc_counter    = (state_reg == ST_WRITEBACK);
    assign dbus_re          = (state_reg == ST_EXECUTE) && re_dec;
    assign dbus_we          = (state_reg == ST_EXECUTE) && we_dec;
    assign pc_src_alu       = (state_reg != ST_FETCH) && pc_src_dec;
    assign branching        = (state_reg != ST_FETCH) && branch_dec;
    assign dest_reg_from    = (state_reg == ST_FETCH) ? DEST_NONE : dest_dec;

    rv32i_alu #(.XLEN(XLEN)) u_alu (
        .mode   (mode_dec),
        .in_a   (alu_in_a),
        .in_b   (alu_in_b),
        .result (alu_out),
        .zero   (alu_zero)
    );

endmodule

// File: tb/tb_rv32i_control_path.sv
// Directed bench for rv32i_control_path: decode, ALU and sequencer stepping.
module tb_rv32i_control_path;
    import rv32i_control_path_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir;
    logic        stall;
    logic [31:0] alu_in_a, alu_in_b, alu_out, imm, len;
    logic        alu_zero;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  alu_mode;
    logic        invert_logic_result, alu_in_a_sel, alu_in_b_sel;
    logic [1:0]  dest_reg_from;
    logic        pc_src_alu, branching, dbus_re, dbus_we;
    logic        load_ir, en_iaddr, en_pc_counter, write_back_stage;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv32i_control_path dut (
        .clk(clk), .rst(rst), .ir(ir), .stall(stall),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_out(alu_out), .alu_zero(alu_zero),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .f3(f3), .f7(f7),
        .imm(imm), .len(len), .alu_mode(alu_mode),
        .invert_logic_result(invert_logic_result),
        .alu_in_a_sel(alu_in_a_sel), .alu_in_b_sel(alu_in_b_sel),
        .dest_reg_from(dest_reg_from), .pc_src_alu(pc_src_alu), .branching(branching),
        .dbus_re(dbus_re), .dbus_we(dbus_we), .load_ir(load_ir), .en_iaddr(en_iaddr),
        .en_pc_counter(en_pc_counter), .write_back_stage(write_back_stage)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {load_ir, en_iaddr, write_back_stage, en_pc_counter} per stage
    task automatic chk_stage(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, load_ir, en_iaddr, write_back_stage, en_pc_counter}, {28'd0, exp});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ir = 32'h00000013;
        alu_in_a = 32'd0; alu_in_b = 32'd0;
        #3;
        chk_stage("reset_fetch", 4'b1100);
        chk("reset_dest", {30'd0, dest_reg_from}, 32'd0);
        chk("reset_len", len, 32'd4);
        @(negedge clk); rst = 1'b0;

        // ADDI x1,x0,5 through all three stages
        ir = 32'h00500093;
        #1;
        chk("addi_fetch_dest", {30'd0, dest_reg_from}, 32'd0);
        step();
        chk_stage("addi_exec_stage", 4'b0000);
        chk("addi_rd", {27'd0, rd}, 32'd1);
        chk("addi_rs1", {27'd0, rs1}, 32'd0);
        chk("addi_imm", imm, 32'd5);
        chk("addi_mode", {28'd0, alu_mode}, {28'd0, ALU_ADD});
        chk("addi_bsel", {31'd0, alu_in_b_sel}, 32'd1);
        chk("addi_dest", {30'd0, dest_reg_from}, 32'd1);
        step();
        chk_stage("addi_wb_stage", 4'b0011);
        chk("addi_wb_dest", {30'd0, dest_reg_from}, 32'd1);
        step();
        chk_stage("back_to_fetch", 4'b1100);
        $display("txn ADDI done");

        // SUB x3,x1,x2 with a=7, b=9
        ir = 32'h402081B3; alu_in_a = 32'd7; alu_in_b = 32'd9;
        step();
        chk("sub_mode", {28'd0, alu_mode}, {28'd0, ALU_SUB});
        chk("sub_rd", {27'd0, rd}, 32'd3);
        chk("sub_bsel", {31'd0, alu_in_b_sel}, 32'd0);
        chk("sub_out", alu_out, 32'hFFFFFFFE);
        chk("sub_zero", {31'd0, alu_zero}, 32'd0);
        step(); step();
        $display("txn SUB done");

        // BEQ x1,x2,+8
        ir = 32'h00208463; alu_in_a = 32'd5; alu_in_b = 32'd5;
        #1;
        chk("beq_fetch_branching", {31'd0, branching}, 32'd0);
        step();
        chk("beq_imm", imm, 32'd8);
        chk("beq_mode", {28'd0, alu_mode}, {28'd0, ALU_SUB});
        chk("beq_invert", {31'd0, invert_logic_result}, 32'd1);
        chk("beq_branching", {31'd0, branching}, 32'd1);
        chk("beq_dest", {30'd0, dest_reg_from}, 32'd0);
        chk("beq_zero", {31'd0, alu_zero}, 32'd1);
        step(); step();
        $display("txn BEQ done");

        // LUI: decode is combinational, checked in FETCH
        ir = 32'h123452B7;
        #1;
        chk("lui_imm", imm, 32'h12345000);
        chk("lui_mode", {28'd0, alu_mode}, {28'd0, ALU_PASS_B});
        $display("txn LUI done");

        // SW x2,4(x1), with a 3-cycle stall in EXECUTE
        ir = 32'h0020A223;
        #1;
        chk("sw_imm", imm, 32'd4);
        chk("sw_fetch_we", {31'd0, dbus_we}, 32'd0);
        stall = 1'b0;
        step();
        chk("sw_exec_we", {31'd0, dbus_we}, 32'd1);
        chk("sw_exec_re", {31'd0, dbus_re}, 32'd0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_stage($sformatf("stall_hold_%0d", i), 4'b0000);
            chk($sformatf("stall_we_%0d", i), {31'd0, dbus_we}, 32'd1);
        end
        stall = 1'b0;
        step();
        chk_stage("stall_release_wb", 4'b0011);
        chk("sw_wb_we", {31'd0, dbus_we}, 32'd0);
        step();
        chk_stage("stall_then_fetch", 4'b1100);
        $display("txn SW+stall done");

        // JAL x1,-4
        ir = 32'hFFDFF0EF;
        step();
        chk("jal_imm", imm, 32'hFFFFFFFC);
        chk("jal_pcsrc", {31'd0, pc_src_alu}, 32'd1);
        chk("jal_dest", {30'd0, dest_reg_from}, 32'd3);
        chk("jal_asel", {31'd0, alu_in_a_sel}, 32'd1);
        step();
        // Asynchronous reset while in WRITEBACK
        chk_stage("pre_reset_wb", 4'b0011);
        #2 rst = 1'b1;
        #1;
        chk_stage("async_reset_fetch", 4'b1100);
        chk("async_reset_pcsrc", {31'd0, pc_src_alu}, 32'd0);
        @(negedge clk); rst = 1'b0;
        $display("txn JAL+reset done");

        // LOAD strobe: LW x5,0(x1)
        ir = 32'h0000A283;
        step();
        chk("lw_re", {31'd0, dbus_re}, 32'd1);
        chk("lw_dest", {30'd0, dest_reg_from}, 32'd2);
        step(); step();
        $display("txn LW done");

        // ALU corner cases (decode only, sequencer state irrelevant)
        ir = 32'h40005033; alu_in_a = 32'h80000000; alu_in_b = 32'd4; #1;
        chk("sra_out", alu_out, 32'hF8000000);
        ir = 32'h00002033; alu_in_a = 32'hFFFFFFFF; alu_in_b = 32'd1; #1;
        chk("slt_out", alu_out, 32'd1);
        ir = 32'h00003033; #1;
        chk("sltu_out", alu_out, 32'd0);
        ir = 32'h00001033; alu_in_a = 32'h00000003; alu_in_b = 32'd33; #1;
        chk("sll33_out", alu_out, 32'h00000006);
        ir = 32'h40000013; alu_in_a = 32'd5; alu_in_b = 32'd3; #1;
        chk("addi_not_sub", alu_out, 32'd8);
        ir = 32'h40005013; alu_in_a = 32'h80000000; alu_in_b = 32'd4; #1;
        chk("srai_mode", {28'd0, alu_mode}, {28'd0, ALU_SRA});
        ir = 32'h0000100F; #1;
        chk("fence_nop_mode", {28'd0, alu_mode}, {28'd0, ALU_ADD});
        $display("txn ALU corners done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, required finish before 50000");
        $fatal(1);
    end

endmodule
